uart_frame_chk: RTL and testbench

UART_FRAME_CHK -- requirements
Module: uart_frame_chk

---
 rtl/uart_chk_pkg.sv | 28 ++
 rtl/uart_frame_chk_if.sv | 52 +++++
 rtl/uart_frame_chk_sat_cnt.sv | 22 ++
 rtl/uart_frame_chk.sv | 140 ++++++++++++++
 tb/tb_uart_frame_chk.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_chk_pkg.sv
// Shared types for the UART frame checker: FSM state encoding, parity modes,
// and the expected-parity helper.
package uart_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_PARITY = 3'd2,
      ST_STOP1  = 3'd3,
      ST_STOP2  = 3'd4
   } state_t;

   localparam logic [1:0] PAR_EVEN  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_MARK  = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

   // x is the XOR of all data bits of the frame
   function automatic logic exp_par_bit(input logic [1:0] mode, input logic x);
      case (mode)
         PAR_EVEN: return x;
         PAR_ODD:  return ~x;
         PAR_MARK: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_frame_chk_if.sv
// Bit-stream in / frame result out bundle for uart_frame_chk.
// FRAME_ERR_CNT_EN adds clr_cnt and the two error counters.
interface uart_frame_chk_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   // Handshake: bit_valid is a one-cycle strobe with no back-pressure; every
   // cycle with bit_valid=1 consumes sampled_bit. data_vld/strt_err are
   // one-cycle result pulses and par_err/stp_err are only meaningful with data_vld.
   logic              bit_valid;
   logic              sampled_bit;
   logic              par_en;
   logic [1:0]        par_mode;
   logic              stop2;
   logic [DATA_W-1:0] p_data;
   logic              data_vld;
   logic              par_err;
   logic              stp_err;
   logic              strt_err;
   logic              busy;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("uart_frame_chk_if: CNT_W must be at least 1");
   end

`ifdef FRAME_ERR_CNT_EN
   logic              clr_cnt;
   logic [CNT_W-1:0]  par_err_cnt;
   logic [CNT_W-1:0]  stp_err_cnt;

   modport master (
      output bit_valid, sampled_bit, par_en, par_mode, stop2, clr_cnt,
      input  p_data, data_vld, par_err, stp_err, strt_err, busy,
             par_err_cnt, stp_err_cnt
   );
   modport slave (
      input  bit_valid, sampled_bit, par_en, par_mode, stop2, clr_cnt,
      output p_data, data_vld, par_err, stp_err, strt_err, busy,
             par_err_cnt, stp_err_cnt
   );
`else
   modport master (
      output bit_valid, sampled_bit, par_en, par_mode, stop2,
      input  p_data, data_vld, par_err, stp_err, strt_err, busy
   );
   modport slave (
      input  bit_valid, sampled_bit, par_en, par_mode, stop2,
      output p_data, data_vld, par_err, stp_err, strt_err, busy
   );
`endif

endinterface

// File: rtl/uart_frame_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_frame_chk.sv
// UART frame checker: deframes start/data/parity/stop bits from a sampled
// bit stream. FRAME_ERR_CNT_EN adds saturating parity/stop error counters.
module uart_frame_chk
   import uart_chk_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   uart_frame_chk_if.slave    bus,
   output state_t             dbg_state
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

   if (DATA_W < 5 || DATA_W > 9 || CNT_W < 1) begin : g_bad_param
      $error("uart_frame_chk: DATA_W must be 5..9 and CNT_W at least 1");
   end

   state_t            state;
   logic [3:0]        bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_acc;
   logic              par_pend;
   logic              l_par_en;
   logic [1:0]        l_par_mode;
   logic              l_stop2;
   logic [DATA_W-1:0] p_data_q;
   logic              data_vld_q;
   logic              par_err_q;
   logic              stp_err_q;
   logic              strt_err_q;
   logic              frame_end;

   // A frame ends on the last stop bit, or early on a bad first stop bit.
   always_comb begin
      frame_end = 1'b0;
      if (bus.bit_valid) begin
         if (state == ST_STOP2) begin
            frame_end = 1'b1;
         end else if (state == ST_STOP1) begin
            frame_end = !bus.sampled_bit || !l_stop2;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_acc    <= 1'b0;
         par_pend   <= 1'b0;
         l_par_en   <= 1'b0;
         l_par_mode <= 2'b00;
         l_stop2    <= 1'b0;
         p_data_q   <= '0;
         data_vld_q <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
         strt_err_q <= 1'b0;
      end else begin
         data_vld_q <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
         strt_err_q <= 1'b0;
         if (bus.bit_valid) begin
            case (state)
               ST_IDLE: begin
                  if (!bus.sampled_bit) begin
                     l_par_en   <= bus.par_en;
                     l_par_mode <= bus.par_mode;
                     l_stop2    <= bus.stop2;
                     bit_cnt    <= '0;
                     par_acc    <= 1'b0;
                     par_pend   <= 1'b0;
                     state      <= ST_DATA;
                  end else begin
                     strt_err_q <= 1'b1;
                  end
               end
               ST_DATA: begin
                  shreg   <= {bus.sampled_bit, shreg[DATA_W-1:1]};
                  par_acc <= par_acc ^ bus.sampled_bit;
                  if (bit_cnt == LAST_BIT) begin
                     state <= l_par_en ? ST_PARITY : ST_STOP1;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               ST_PARITY: begin
                  par_pend <= bus.sampled_bit != exp_par_bit(l_par_mode, par_acc);
                  state    <= ST_STOP1;
               end
               ST_STOP1: begin
                  if (bus.sampled_bit && l_stop2) begin
                     state <= ST_STOP2;
                  end
               end
               default: state <= ST_IDLE;
            endcase
            if (frame_end) begin
               data_vld_q <= 1'b1;
               par_err_q  <= par_pend;
               stp_err_q  <= !bus.sampled_bit;
               p_data_q   <= shreg;
               state      <= ST_IDLE;
            end
         end
      end
   end

   assign bus.p_data   = p_data_q;
   assign bus.data_vld = data_vld_q;
   assign bus.par_err  = par_err_q;
   assign bus.stp_err  = stp_err_q;
   assign bus.strt_err = strt_err_q;
   assign bus.busy     = (state != ST_IDLE);
   assign dbg_state    = state;

`ifdef FRAME_ERR_CNT_EN
   sat_cnt #(.CNT_W(CNT_W)) u_par_cnt (
      .clk (clk),
      .rst (rst),
      .inc (data_vld_q & par_err_q),
      .clr (bus.clr_cnt),
      .cnt (bus.par_err_cnt)
   );

   sat_cnt #(.CNT_W(CNT_W)) u_stp_cnt (
      .clk (clk),
      .rst (rst),
      .inc (data_vld_q & stp_err_q),
      .clr (bus.clr_cnt),
      .cnt (bus.stp_err_cnt)
   );
`endif

endmodule

// File: tb/tb_uart_frame_chk.sv
// Self-checking bench for uart_frame_chk (DATA_W=8, CNT_W=2); counter checks
// are compiled in when FRAME_ERR_CNT_EN is defined.
module tb_uart_frame_chk;
   import uart_chk_pkg::*;

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic [1:0] mode;
      logic       stop2;
      logic       pbit;
      logic       s1;
      logic       s2;
      logic       exp_pe;
      logic       exp_se;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_frame_chk_if #(.DATA_W(8), .CNT_W(2)) u_if ();
   state_t dbg_state;

   uart_frame_chk #(.DATA_W(8), .CNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (u_if),
      .dbg_state (dbg_state)
   );

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   vec_t vecs[10];
   int exp_pc = 0;
   int exp_sc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every data_vld must match the oldest expected word
   always @(posedge clk) begin
      #1;
      if (u_if.data_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_data_vld: got p_data %0h expected no frame", u_if.p_data);
         end else begin
            check("sb_p_data", 32'(u_if.p_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks
   task automatic strobe_now(input logic b);
      u_if.bit_valid   = 1'b1;
      u_if.sampled_bit = b;
      @(negedge clk);
      u_if.bit_valid   = 1'b0;
      u_if.sampled_bit = 1'b1;
   endtask

   task automatic strobe(input logic b);
      @(negedge clk);
      strobe_now(b);
   endtask

   task automatic send_frame(input vec_t v);
      u_if.par_en   = v.par_en;
      u_if.par_mode = v.mode;
      u_if.stop2    = v.stop2;
      strobe(1'b0);
      u_if.par_en   = 1'($urandom_range(0, 1));
      u_if.par_mode = 2'($urandom_range(0, 3));
      u_if.stop2    = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) strobe(v.data[i]);
      if (v.par_en) strobe(v.pbit);
      if (!v.s1 || !v.stop2) begin
         exp_q.push_back(v.data);
         strobe(v.s1);
      end else begin
         strobe(1'b1);
         exp_q.push_back(v.data);
         strobe(v.s2);
      end
   endtask

   task automatic check_counters(input string tag);
`ifdef FRAME_ERR_CNT_EN
      check({tag, "_par_cnt"}, 32'(u_if.par_err_cnt), 32'(exp_pc));
      check({tag, "_stp_cnt"}, 32'(u_if.stp_err_cnt), 32'(exp_sc));
`else
      check({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
`endif
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b1, PAR_EVEN,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b1, PAR_ODD,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b1, PAR_ODD,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h3C, 1'b0, PAR_EVEN,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h7E, 1'b1, PAR_MARK,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 1'b1, PAR_SPACE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{8'hFF, 1'b1, PAR_EVEN,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{8'h55, 1'b0, PAR_EVEN,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{8'h00, 1'b1, PAR_EVEN,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{8'hC3, 1'b1, PAR_ODD,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      u_if.bit_valid   = 1'b0;
      u_if.sampled_bit = 1'b1;
      u_if.par_en      = 1'b0;
      u_if.par_mode    = PAR_EVEN;
      u_if.stop2       = 1'b0;
`ifdef FRAME_ERR_CNT_EN
      u_if.clr_cnt     = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_p_data",   32'(u_if.p_data),   32'h0);
      check("rst_data_vld", 32'(u_if.data_vld), 32'h0);
      check("rst_par_err",  32'(u_if.par_err),  32'h0);
      check("rst_stp_err",  32'(u_if.stp_err),  32'h0);
      check("rst_strt_err", 32'(u_if.strt_err), 32'h0);
      check("rst_busy",     32'(u_if.busy),     32'h0);
      check("rst_state",    32'(dbg_state),     32'(ST_IDLE));
      check_counters("rst");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // table-driven frames
      for (int i = 0; i < 10; i++) begin
         send_frame(vecs[i]);
         check($sformatf("v%0d_data_vld", i), 32'(u_if.data_vld), 32'h1);
         check($sformatf("v%0d_p_data", i),   32'(u_if.p_data),   32'(vecs[i].data));
         check($sformatf("v%0d_par_err", i),  32'(u_if.par_err),  32'(vecs[i].exp_pe));
         check($sformatf("v%0d_stp_err", i),  32'(u_if.stp_err),  32'(vecs[i].exp_se));
         check($sformatf("v%0d_busy", i),     32'(u_if.busy),     32'h0);
         if (vecs[i].exp_pe && exp_pc < 3) exp_pc++;
         if (vecs[i].exp_se && exp_sc < 3) exp_sc++;
         @(negedge clk);
         check($sformatf("v%0d_vld_clear", i), 32'(u_if.data_vld), 32'h0);
         check($sformatf("v%0d_err_clear", i), 32'({u_if.par_err, u_if.stp_err}), 32'h0);
         check($sformatf("v%0d_p_hold", i),    32'(u_if.p_data),   32'(vecs[i].data));
         check_counters($sformatf("v%0d", i));
      end

      // false start bit
      strobe(1'b1);
      check("strt_err_pulse", 32'(u_if.strt_err), 32'h1);
      check("strt_busy",      32'(u_if.busy),     32'h0);
      @(negedge clk);
      check("strt_err_clear", 32'(u_if.strt_err), 32'h0);
      check("strt_state",     32'(dbg_state),     32'(ST_IDLE));

      // bad first stop bit with stop2, then back-to-back start in the data_vld cycle
      u_if.par_en = 1'b0;
      u_if.stop2  = 1'b1;
      strobe(1'b0);
      for (int i = 0; i < 8; i++) strobe(1'((8'h12 >> i) & 8'h01));
      exp_q.push_back(8'h12);
      strobe(1'b0);
      check("b2b_vld",     32'(u_if.data_vld), 32'h1);
      check("b2b_stp_err", 32'(u_if.stp_err),  32'h1);
      check("b2b_p_data",  32'(u_if.p_data),   32'h12);
      strobe_now(1'b0);
      check("b2b_busy",    32'(u_if.busy),     32'h1);
      check("b2b_state",   32'(dbg_state),     32'(ST_DATA));
      for (int i = 0; i < 8; i++) strobe(1'((8'h34 >> i) & 8'h01));
      strobe(1'b1);
      exp_q.push_back(8'h34);
      strobe(1'b1);
      check("b2b2_vld",     32'(u_if.data_vld), 32'h1);
      check("b2b2_p_data",  32'(u_if.p_data),   32'h34);
      check("b2b2_stp_err", 32'(u_if.stp_err),  32'h0);
      exp_sc = (exp_sc < 3) ? exp_sc + 1 : 3;

      // reset in the middle of a frame
      u_if.par_en   = 1'b1;
      u_if.par_mode = PAR_EVEN;
      u_if.stop2    = 1'b0;
      strobe(1'b0);
      for (int i = 0; i < 4; i++) strobe(1'((8'h3C >> i) & 8'h01));
      check("mid_busy_pre", 32'(u_if.busy), 32'h1);
      rst = 1'b0;
      #1;
      check("mid_rst_busy",   32'(u_if.busy),     32'h0);
      check("mid_rst_vld",    32'(u_if.data_vld), 32'h0);
      check("mid_rst_p_data", 32'(u_if.p_data),   32'h0);
      check("mid_rst_state",  32'(dbg_state),     32'(ST_IDLE));
      exp_pc = 0;
      exp_sc = 0;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("mid_no_vld", 32'(u_if.data_vld), 32'h0);
      check_counters("mid");
      send_frame('{8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      check("clean_vld",     32'(u_if.data_vld), 32'h1);
      check("clean_p_data",  32'(u_if.p_data),   32'h3C);
      check("clean_par_err", 32'(u_if.par_err),  32'h0);
      check("clean_stp_err", 32'(u_if.stp_err),  32'h0);
      @(negedge clk);

`ifdef FRAME_ERR_CNT_EN
      // counter saturation and clear-over-increment
      for (int k = 0; k < 5; k++) begin
         send_frame(vecs[1]);
         @(negedge clk);
      end
      check("sat_par_cnt", 32'(u_if.par_err_cnt), 32'h3);
      check("sat_stp_cnt", 32'(u_if.stp_err_cnt), 32'h0);
      u_if.clr_cnt = 1'b1;
      send_frame(vecs[1]);
      check("clr_par_err", 32'(u_if.par_err), 32'h1);
      @(negedge clk);
      u_if.clr_cnt = 1'b0;
      check("clr_par_cnt", 32'(u_if.par_err_cnt), 32'h0);
      @(negedge clk);
      check("clr_par_cnt_hold", 32'(u_if.par_err_cnt), 32'h0);
`endif

      repeat (3) @(negedge clk);
      check("sb_pending", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
